// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bp_pkg
// Description : Shared constants for the branch prediction slice.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // A freshly allocated branch has just been seen taken, so start weakly taken.
    localparam logic [1:0] CTR_INIT_ALLOC = CTR_WT;

    localparam int IDX_W_DEFAULT = 6;

endpackage
`default_nettype wire

// File: rtl/sat_ctr2.sv
`default_nettype none
// ============================================================================
// Module      : sat_ctr2
// Description : Combinational 2-bit saturating direction counter update.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped BTB with 2-bit direction counters; IF lookup,
//               EX resolution/update and retirement statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEFAULT,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_IF,
    output logic [31:0] NPC_predicted_IF,
    output logic        found_IF,
    output logic        pred_taken_IF,
    input  logic [31:0] PC_EX,
    input  logic        br_EX,
    input  logic        br,
    input  logic [31:0] br_target,
    input  logic        found_EX,
    input  logic        pred_taken_EX,
    input  logic        stall_EX,
    output logic        fail,
    output logic [31:0] br_count,
    output logic [31:0] miss_count
);

    localparam int ENTRIES = 1 << IDX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_eidx;
    logic [TAG_W-1:0] w_etag;
    logic             w_hit;
    logic             w_upd;
    logic [1:0]       w_ctr_next;
    logic             w_unused_bits;

    assign w_idx  = PC_IF[IDX_W+1:2];
    assign w_tag  = PC_IF[31:IDX_W+2];
    assign w_eidx = PC_EX[IDX_W+1:2];
    assign w_etag = PC_EX[31:IDX_W+2];

    // Instruction alignment bits carry no index or tag information.
    assign w_unused_bits = ^{PC_IF[1:0], PC_EX[1:0]};

    assign w_hit            = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign found_IF         = w_hit;
    assign pred_taken_IF    = w_hit && r_ctr[w_idx][1];
    assign NPC_predicted_IF = pred_taken_IF ? r_target[w_idx] : PC_IF + 32'd4;

    assign fail  = br_EX && (pred_taken_EX != br);
    assign w_upd = br_EX && !stall_EX;

    sat_ctr2 u_sat_ctr2 (
        .ctr      (r_ctr[w_eidx]),
        .taken    (br),
        .ctr_next (w_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CTR_SNT;
            end
            br_count   <= 32'd0;
            miss_count <= 32'd0;
        end else if (w_upd) begin
            br_count <= br_count + 32'd1;
            if (fail) miss_count <= miss_count + 32'd1;
            // A stale hit still updates whichever entry now occupies eidx.
            if (found_EX) begin
                r_ctr[w_eidx] <= w_ctr_next;
            end else if (br) begin
                r_valid[w_eidx] <= 1'b1;
                r_ctr[w_eidx]   <= CTR_INIT_ALLOC;
            end
        end
    end

    // Tag and target carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (!rst && w_upd && br) begin
            r_target[w_eidx] <= br_target;
            if (!found_EX) r_tag[w_eidx] <= w_etag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_buffer
// Description : Directed self-checking bench for branch_target_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_IF;
    logic [31:0] NPC_predicted_IF;
    logic        found_IF;
    logic        pred_taken_IF;
    logic [31:0] PC_EX;
    logic        br_EX;
    logic        br;
    logic [31:0] br_target;
    logic        found_EX;
    logic        pred_taken_EX;
    logic        stall_EX;
    logic        fail;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_target_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .PC_IF            (PC_IF),
        .NPC_predicted_IF (NPC_predicted_IF),
        .found_IF         (found_IF),
        .pred_taken_IF    (pred_taken_IF),
        .PC_EX            (PC_EX),
        .br_EX            (br_EX),
        .br               (br),
        .br_target        (br_target),
        .found_EX         (found_EX),
        .pred_taken_EX    (pred_taken_EX),
        .stall_EX         (stall_EX),
        .fail             (fail),
        .br_count         (br_count),
        .miss_count       (miss_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic exp_found,
                          input logic [31:0] exp_npc, input string tag);
        PC_IF = pc;
        #1;
        check({tag, "_found"}, {31'd0, found_IF}, {31'd0, exp_found});
        check({tag, "_npc"}, NPC_predicted_IF, exp_npc);
    endtask

    task automatic ex(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                      input logic fnd, input logic pt);
        PC_EX = pc; br_EX = 1'b1; br = taken; br_target = tgt;
        found_EX = fnd; pred_taken_EX = pt;
        #1;
    endtask

    task automatic ex_idle();
        br_EX = 1'b0; br = 1'b0; found_EX = 1'b0; pred_taken_EX = 1'b0;
    endtask

    initial begin
        rst = 1'b1; PC_IF = 32'h0; PC_EX = 32'h0; br_target = 32'h0;
        stall_EX = 1'b0;
        ex_idle();
        step(); step();
        rst = 1'b0;

        lookup(32'h100, 1'b0, 32'h104, "rst_lookup");
        check("rst_pred", {31'd0, pred_taken_IF}, 32'd0);
        check("rst_brcnt", br_count, 32'd0);
        check("rst_misscnt", miss_count, 32'd0);
        lookup(32'hFFFF_FFFC, 1'b0, 32'h0, "wrap_npc");

        // Allocate taken branch at 0x100.
        ex(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
        check("alloc_fail", {31'd0, fail}, 32'd1);
        lookup(32'h100, 1'b0, 32'h104, "no_bypass");
        step(); ex_idle();
        lookup(32'h100, 1'b1, 32'h80, "alloc_hit");
        check("alloc_pred", {31'd0, pred_taken_IF}, 32'd1);
        check("alloc_brcnt", br_count, 32'd1);
        check("alloc_misscnt", miss_count, 32'd1);

        // Counter 10 -> 01 -> 00.
        ex(32'h100, 1'b0, 32'h0, 1'b1, 1'b1);
        check("dec1_fail", {31'd0, fail}, 32'd1);
        step(); ex_idle();
        lookup(32'h100, 1'b1, 32'h104, "dec1");
        check("dec1_pred", {31'd0, pred_taken_IF}, 32'd0);
        ex(32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
        check("dec2_fail", {31'd0, fail}, 32'd0);
        step(); ex_idle();
        lookup(32'h100, 1'b1, 32'h104, "dec2");
        check("dec2_brcnt", br_count, 32'd3);
        check("dec2_misscnt", miss_count, 32'd2);

        // 00 -> 01 -> 10 with target rewrite to 0x90.
        ex(32'h100, 1'b1, 32'h90, 1'b1, 1'b0);
        step(); ex_idle();
        lookup(32'h100, 1'b1, 32'h104, "inc1");
        ex(32'h100, 1'b1, 32'h90, 1'b1, 1'b0);
        step(); ex_idle();
        lookup(32'h100, 1'b1, 32'h90, "inc2_retarget");
        check("inc2_brcnt", br_count, 32'd5);
        check("inc2_misscnt", miss_count, 32'd4);

        // Alias 0x200 onto the same index.
        ex(32'h200, 1'b1, 32'h40, 1'b0, 1'b0);
        step(); ex_idle();
        lookup(32'h100, 1'b0, 32'h104, "alias_old");
        lookup(32'h200, 1'b1, 32'h40, "alias_new");

        // Non-branch never fails.
        br_EX = 1'b0; pred_taken_EX = 1'b1; br = 1'b0;
        #1;
        check("nonbr_fail", {31'd0, fail}, 32'd0);
        ex_idle();

        // Stall three cycles on a miss, then release.
        stall_EX = 1'b1;
        ex(32'h304, 1'b1, 32'h500, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_fail", {31'd0, fail}, 32'd1);
            step();
            lookup(32'h304, 1'b0, 32'h308, "stall_lookup");
            check("stall_brcnt", br_count, 32'd6);
        end
        stall_EX = 1'b0;
        step(); ex_idle();
        lookup(32'h304, 1'b1, 32'h500, "release");
        check("release_brcnt", br_count, 32'd7);
        check("release_misscnt", miss_count, 32'd6);
        step();
        check("release_once", br_count, 32'd7);

        // Saturation at strongly taken: 10 -> 11 -> 11 -> 10.
        ex(32'h304, 1'b1, 32'h500, 1'b1, 1'b1);
        check("sat_fail", {31'd0, fail}, 32'd0);
        step();
        step();
        ex(32'h304, 1'b0, 32'h0, 1'b1, 1'b1);
        step(); ex_idle();
        lookup(32'h304, 1'b1, 32'h500, "sat_hold");
        check("sat_pred", {31'd0, pred_taken_IF}, 32'd1);
        check("sat_brcnt", br_count, 32'd10);
        check("sat_misscnt", miss_count, 32'd7);

        // Reset wins over a simultaneous allocation.
        rst = 1'b1;
        ex(32'h408, 1'b1, 32'h600, 1'b0, 1'b0);
        step();
        rst = 1'b0; ex_idle();
        lookup(32'h408, 1'b0, 32'h40C, "rstupd_alloc");
        lookup(32'h200, 1'b0, 32'h204, "rstupd_clear");
        lookup(32'h304, 1'b0, 32'h308, "rstupd_clear2");
        check("rstupd_brcnt", br_count, 32'd0);
        check("rstupd_misscnt", miss_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters. It is the prediction side of the next-PC path. In IF it looks up the fetch PC and drives the predicted next PC and a hit flag, which the pipeline carries to EX. In EX it takes the resolved branch outcome, raises `fail` on a misprediction for the NPC generator, and updates the table and the statistics counters.

## Interface
Parameters:
- `IDX_W`, default 6: index width; number of entries is 2^IDX_W.
- `TAG_W`, default 30-IDX_W: tag width, taken from PC[31:IDX_W+2].

Ports:
- `clk` in 1: clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `PC_IF` in 32: address of the instruction being fetched.
- `NPC_predicted_IF` out 32: predicted next fetch address.
- `found_IF` out 1: `PC_IF` hit a valid entry.
- `pred_taken_IF` out 1: hit and counter[1]=1. The pipeline carries this to EX.
- `PC_EX` in 32: address of the instruction in EX.
- `br_EX` in 1: the instruction in EX is a conditional branch and is not flushed.
- `br` in 1: the branch in EX resolved taken.
- `br_target` in 32: resolved branch target.
- `found_EX` in 1: pipelined copy of `found_IF`.
- `pred_taken_EX` in 1: pipelined copy of `pred_taken_IF`.
- `stall_EX` in 1: EX is held; suppresses all state updates.
- `fail` out 1: misprediction in EX.
- `br_count` out 32: number of branches retired.
- `miss_count` out 32: number of mispredictions.

## Operation
- Each entry holds `valid`, `tag[TAG_W]`, `target[32]` and `ctr[2]`.
- Counter encoding: 00 strongly not taken, 01 weakly not taken, 10 weakly taken, 11 strongly taken.
- Lookup is combinational:
  - idx = `PC_IF`[IDX_W+1:2].
  - hit = valid[idx] and tag[idx] == `PC_IF`[31:IDX_W+2].
  - `found_IF` = hit.
  - `pred_taken_IF` = hit and ctr[idx][1].
  - `NPC_predicted_IF` = `pred_taken_IF` ? target[idx] : `PC_IF`+4. Addition is modulo 2^32; 0xFFFFFFFC+4 = 0.
- `fail` is combinational: `br_EX` and (`pred_taken_EX` != `br`). Non-branches in EX never fail; they are never allocated, so they never predict taken.
- Update happens at the clock edge when `br_EX`=1 and `stall_EX`=0. eidx and etag are derived from `PC_EX` the same way as for lookup.
  - `found_EX`=1: ctr saturating-increments if `br`=1 and saturating-decrements if `br`=0. If `br`=1, target is also rewritten with `br_target`.
  - `found_EX`=0 and `br`=1: allocate the entry, overwriting any conflicting entry. Set valid=1, tag=etag, target=`br_target`, ctr=10.
  - `found_EX`=0 and `br`=0: no table change.
  - `br_count` increments by 1.
  - `miss_count` increments by 1 if `fail`.
- Both statistics counters wrap from 0xFFFFFFFF to 0.
- A stale `found_EX`, caused by the entry being replaced between IF and EX, is used as-is. The hit case then updates the counter of whichever entry sits at eidx. This is accepted behaviour.

## Timing
- Lookup has zero-cycle latency; `PC_IF` to outputs is purely combinational.
- An update becomes visible to lookup on the cycle after the edge that writes it. A lookup and an update to the same index in the same cycle return the old contents; there is no bypass.
- Reset clears all `valid` bits, all `ctr` fields to 00, and `br_count`/`miss_count` to 0. `tag` and `target` are don't-care.
- Outputs after reset:
  - `found_IF`=0, `pred_taken_IF`=0, `NPC_predicted_IF`=`PC_IF`+4.
  - `fail`=0 while `br_EX`=0 or `pred_taken_EX`=`br`.
- Reset has priority over a simultaneous update; an update in the reset cycle is discarded.
- While `stall_EX`=1, `fail` still reflects its inputs. The update is applied exactly once, in the first cycle `stall_EX`=0.

## Structure
- Package `bp_pkg` holds:
  - the counter encoding constants: `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`;
  - the `CTR_INIT_ALLOC` constant (= `CTR_WT`);
  - the default `IDX_W`.
- Sub-module `sat_ctr2`: combinational 2-bit saturating update, inputs ctr and taken, output next ctr.
- The table is held in flat registers, not block RAM, because lookup is asynchronous.

## Test plan
- Reset, then `PC_IF`=0x100: `found_IF`=0, `NPC_predicted_IF`=0x104. `br_count` and `miss_count` are 0.
- EX branch at `PC_EX`=0x100, `br`=1, `br_target`=0x80, `found_EX`=0, `pred_taken_EX`=0: `fail`=1. Next cycle, `PC_IF`=0x100 gives `found_IF`=1 and `NPC_predicted_IF`=0x80. `br_count`=1, `miss_count`=1.
- Same branch resolved `br`=0 twice with `found_EX`=1 (`pred_taken_EX`=1 first, then 0): ctr goes 10→01→00. The first resolution asserts `fail`; after it the prediction is 0x104 and `found_IF` stays 1.
- Aliasing: with `IDX_W`=6, allocate 0x100 taken, then allocate 0x200 taken with target 0x40 (same index, different tag). Lookup of 0x100 then misses; lookup of 0x200 predicts 0x40.
- `stall_EX`=1 for 3 cycles with `br_EX`=1 and `br`=1 on a miss: no allocation and `br_count` unchanged during the stall. Exactly one allocation and `br_count`+1 on release.
- `rst` asserted in the same cycle as a qualifying update: table and counters are cleared, and no entry is allocated.
